// File: rtl/imm_pkg.sv
// Shared definitions for the immediate-generation pipeline stage.
//   itype_e   : instruction format code carried alongside each fetched word
//   OP_IMM    : opcode of OP-IMM (addi, slli, srli, srai, ...)
//   OP_IMM_32 : opcode of OP-IMM-32 (addiw, slliw, srliw, sraiw)
package imm_pkg;

    typedef enum logic [2:0] {
        ITYPE_I     = 3'd0,
        ITYPE_U     = 3'd1,
        ITYPE_J     = 3'd2,
        ITYPE_S     = 3'd3,
        ITYPE_B     = 3'd4,
        ITYPE_NONE  = 3'd5,
        ITYPE_Z     = 3'd6,
        ITYPE_SHAMT = 3'd7
    } itype_e;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM_32 = 7'b0011011;

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate extraction for every RV instruction format.
//   inst  : raw 32-bit instruction
//   itype : format code (imm_pkg::itype_e)
//   imm   : sign/zero-extended immediate, XLEN bits
//   bad   : itype not a known format
module imm_extract
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    input  logic [2:0]      itype,
    output logic [XLEN-1:0] imm,
    output logic            bad
);

    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic              shift_op;
    logic [5:0]        shamt;
    logic signed [31:0] imm_i;
    logic signed [31:0] imm_s;
    logic signed [31:0] imm_b;
    logic signed [31:0] imm_u;
    logic signed [31:0] imm_j;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];

    // slli/srli/srai (and their -W forms) are tagged as I-type by fetch, but
    // the upper bits hold funct7/arith rather than immediate bits.
    assign shift_op = ((opcode == OP_IMM) || (opcode == OP_IMM_32)) &&
                      ((funct3 == 3'b001) || (funct3 == 3'b101));

    assign shamt = (XLEN == 64) ? inst[25:20] : {1'b0, inst[24:20]};

    // Every format is first assembled as a signed 32-bit value; the size cast
    // to XLEN then sign-extends bit 31 for the RV64 case.
    assign imm_i = {{20{inst[31]}}, inst[31:20]};
    assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u = {inst[31:12], 12'b0};
    assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    always_comb begin
        imm = '0;
        bad = 1'b0;
        case (itype)
            ITYPE_I: begin
                if (shift_op) imm = XLEN'(shamt);
                else          imm = XLEN'(imm_i);
            end
            ITYPE_U:     imm = XLEN'(imm_u);
            ITYPE_J:     imm = XLEN'(imm_j);
            ITYPE_S:     imm = XLEN'(imm_s);
            ITYPE_B:     imm = XLEN'(imm_b);
            ITYPE_NONE:  imm = '0;
            ITYPE_Z:     imm = XLEN'(inst[19:15]);
            ITYPE_SHAMT: imm = XLEN'(shamt);
            // Every 3-bit code is currently assigned; this arm only matters if
            // the format field is ever widened.
            default:     bad = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate-generation stage between fetch and decode.
// Extracts the immediate on accept and queues {imm, inst, bad} in a small FIFO
// so downstream backpressure never drops an instruction.
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid/in_ready    : input handshake; in_inst, in_itype are the beat
//   flush                : discard all buffered beats, block input this cycle
//   out_valid/out_ready  : output handshake; out_imm, out_inst, out_bad result
//   imm_count            : number of results consumed (wraps)
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [2:0]       in_itype,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [31:0]      out_inst,
    output logic             out_bad,
    output logic [CNT_W-1:0] imm_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int FILL_W = $clog2(DEPTH) + 1;

    logic [XLEN-1:0]   ext_imm;
    logic              ext_bad;

    logic [XLEN-1:0]   imm_mem  [DEPTH];
    logic [31:0]       inst_mem [DEPTH];
    logic              bad_mem  [DEPTH];

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [FILL_W-1:0] count;

    logic [XLEN-1:0]   last_imm;
    logic [31:0]       last_inst;
    logic              last_bad;

    logic              accept;
    logic              xfer;

    imm_extract #(.XLEN(XLEN)) u_extract (
        .inst  (in_inst),
        .itype (in_itype),
        .imm   (ext_imm),
        .bad   (ext_bad)
    );

    assign in_ready  = (count != FILL_W'(DEPTH)) && !flush;
    assign out_valid = (count != '0);
    assign accept    = in_valid && in_ready;
    assign xfer      = out_valid && out_ready;

    // While empty the outputs show the last consumed result; there is no
    // bypass from the extractor, so a beat always costs one cycle.
    assign out_imm  = out_valid ? imm_mem[rd_ptr]  : last_imm;
    assign out_inst = out_valid ? inst_mem[rd_ptr] : last_inst;
    assign out_bad  = out_valid ? bad_mem[rd_ptr]  : last_bad;

    // Storage needs no reset: an entry is only read once count covers it.
    always_ff @(posedge clk) begin
        if (accept) begin
            imm_mem[wr_ptr]  <= ext_imm;
            inst_mem[wr_ptr] <= in_inst;
            bad_mem[wr_ptr]  <= ext_bad;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + PTR_W'(1);
            if (xfer)   rd_ptr <= rd_ptr + PTR_W'(1);
            case ({accept, xfer})
                2'b10:   count <= count + FILL_W'(1);
                2'b01:   count <= count - FILL_W'(1);
                default: count <= count;
            endcase
        end
    end

    // A transfer handshaken in the same cycle as flush still reached the
    // consumer, so it is counted and remembered as the last result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_imm  <= '0;
            last_inst <= '0;
            last_bad  <= 1'b0;
            imm_count <= '0;
        end else if (xfer) begin
            last_imm  <= imm_mem[rd_ptr];
            last_inst <= inst_mem[rd_ptr];
            last_bad  <= bad_mem[rd_ptr];
            imm_count <= imm_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_inst = '0;
    logic [2:0]  in_itype = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_imm;
    logic [31:0] out_inst;
    logic        out_bad;
    logic [31:0] imm_count;

    logic        in_valid64 = 1'b0;
    logic        in_ready64;
    logic [31:0] in_inst64 = '0;
    logic [2:0]  in_itype64 = '0;
    logic        out_valid64;
    logic [63:0] out_imm64;
    logic [31:0] out_inst64;
    logic        out_bad64;
    logic [31:0] imm_count64;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .DEPTH(2), .CNT_W(32)) u_dut32 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_inst   (in_inst),
        .in_itype  (in_itype),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_imm   (out_imm),
        .out_inst  (out_inst),
        .out_bad   (out_bad),
        .imm_count (imm_count)
    );

    imm_gen_pipe #(.XLEN(64), .DEPTH(2), .CNT_W(32)) u_dut64 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid64),
        .in_ready  (in_ready64),
        .in_inst   (in_inst64),
        .in_itype  (in_itype64),
        .flush     (1'b0),
        .out_valid (out_valid64),
        .out_ready (1'b1),
        .out_imm   (out_imm64),
        .out_inst  (out_inst64),
        .out_bad   (out_bad64),
        .imm_count (imm_count64)
    );

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        in_valid64 = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b expected 0", out_valid); end
        vectors++;
        if (out_imm !== 32'h0 || out_inst !== 32'h0 || out_bad !== 1'b0) begin
            miscompares++; $display("FAIL reset_out_data got imm=%h inst=%h bad=%b expected all 0", out_imm, out_inst, out_bad);
        end
        vectors++;
        if (imm_count !== 32'd0) begin miscompares++; $display("FAIL reset_imm_count got %0d expected 0", imm_count); end
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b expected 1", in_ready); end
        vectors++;
        if (out_valid64 !== 1'b0 || out_imm64 !== 64'h0 || in_ready64 !== 1'b1) begin
            miscompares++; $display("FAIL reset_dut64 got valid=%b imm=%h ready=%b expected 0/0/1", out_valid64, out_imm64, in_ready64);
        end
    endtask

    task automatic test_basic();
        logic [31:0] v_inst [5] = '{32'hFFF00093, 32'h123450B7, 32'h008000EF, 32'hFE20AE23, 32'hFE000CE3};
        logic [2:0]  v_type [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
        logic [31:0] v_exp  [5] = '{32'hFFFFFFFF, 32'h12345000, 32'h00000008, 32'hFFFFFFFC, 32'hFFFFFFF8};
        out_ready = 1'b1;
        for (int i = 0; i <= 5; i++) begin
            @(negedge clk);
            if (i > 0) begin
                vectors++;
                if (out_valid !== 1'b1 || out_imm !== v_exp[i-1] || out_inst !== v_inst[i-1] || out_bad !== 1'b0) begin
                    miscompares++;
                    $display("FAIL basic[%0d] got valid=%b imm=%h inst=%h bad=%b expected 1/%h/%h/0",
                             i-1, out_valid, out_imm, out_inst, out_bad, v_exp[i-1], v_inst[i-1]);
                end
            end
            if (i < 5) begin
                vectors++;
                if (in_ready !== 1'b1) begin miscompares++; $display("FAIL basic_in_ready[%0d] got %b expected 1", i, in_ready); end
                in_valid = 1'b1;
                in_inst = v_inst[i];
                in_itype = v_type[i];
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0 || imm_count !== 32'd5 || out_imm !== 32'hFFFFFFF8) begin
            miscompares++;
            $display("FAIL basic_drain got valid=%b count=%0d imm=%h expected 0/5/fffffff8", out_valid, imm_count, out_imm);
        end
    endtask

    task automatic test_shift();
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b1;   in_inst = 32'h4030D093;   in_itype = 3'd0;
        in_valid64 = 1'b1; in_inst64 = 32'h4230D093; in_itype64 = 3'd0;
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b1 || out_imm !== 32'h00000003) begin
            miscompares++; $display("FAIL shift_srai32 got valid=%b imm=%h expected 1/00000003", out_valid, out_imm);
        end
        vectors++;
        if (out_valid64 !== 1'b1 || out_imm64 !== 64'h23) begin
            miscompares++; $display("FAIL shift_srai64 got valid=%b imm=%h expected 1/23", out_valid64, out_imm64);
        end
        // Load with funct3=001 is not a shift: full 12-bit I immediate.
        in_inst = 32'h40109083;   in_itype = 3'd0;
        in_inst64 = 32'h800000B7; in_itype64 = 3'd1;
        @(negedge clk);
        vectors++;
        if (out_imm !== 32'h00000401) begin
            miscompares++; $display("FAIL shift_not_opimm got %h expected 00000401", out_imm);
        end
        vectors++;
        if (out_imm64 !== 64'hFFFFFFFF80000000) begin
            miscompares++; $display("FAIL u64_sign got %h expected ffffffff80000000", out_imm64);
        end
        in_valid = 1'b0;
        in_inst64 = 32'h4050D09B; in_itype64 = 3'd0;
        @(negedge clk);
        vectors++;
        if (out_imm64 !== 64'h5) begin
            miscompares++; $display("FAIL sraiw64 got %h expected 5", out_imm64);
        end
        in_valid64 = 1'b0;
    endtask

    task automatic test_formats();
        logic [31:0] v_inst [3] = '{32'hFFFFFFFF, 32'h000F8073, 32'hFFFFFFFF};
        logic [2:0]  v_type [3] = '{3'd5, 3'd6, 3'd7};
        logic [31:0] v_exp  [3] = '{32'h00000000, 32'h0000001F, 32'h0000001F};
        logic [63:0] v_exp64[3] = '{64'h0, 64'h1F, 64'h3F};
        out_ready = 1'b1;
        for (int i = 0; i <= 3; i++) begin
            @(negedge clk);
            if (i > 0) begin
                vectors++;
                if (out_valid !== 1'b1 || out_imm !== v_exp[i-1] || out_bad !== 1'b0) begin
                    miscompares++;
                    $display("FAIL fmt32[%0d] got valid=%b imm=%h bad=%b expected 1/%h/0", i-1, out_valid, out_imm, out_bad, v_exp[i-1]);
                end
                vectors++;
                if (out_valid64 !== 1'b1 || out_imm64 !== v_exp64[i-1] || out_bad64 !== 1'b0) begin
                    miscompares++;
                    $display("FAIL fmt64[%0d] got valid=%b imm=%h bad=%b expected 1/%h/0", i-1, out_valid64, out_imm64, out_bad64, v_exp64[i-1]);
                end
            end
            if (i < 3) begin
                in_valid = 1'b1;   in_inst = v_inst[i];   in_itype = v_type[i];
                in_valid64 = 1'b1; in_inst64 = v_inst[i]; in_itype64 = v_type[i];
            end else begin
                in_valid = 1'b0;
                in_valid64 = 1'b0;
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; in_inst = 32'h00100093; in_itype = 3'd0;
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_imm !== 32'h1) begin
            miscompares++; $display("FAIL bp_first got ready=%b valid=%b imm=%h expected 1/1/1", in_ready, out_valid, out_imm);
        end
        in_inst = 32'h00200093;
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_full got ready=%b expected 0", in_ready); end
        in_inst = 32'h00300093;
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b0 || out_imm !== 32'h1 || imm_count !== 32'd0) begin
            miscompares++; $display("FAIL bp_hold got ready=%b imm=%h count=%0d expected 0/1/0", in_ready, out_imm, imm_count);
        end
        out_ready = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b1 || out_imm !== 32'h2 || out_inst !== 32'h00200093) begin
            miscompares++; $display("FAIL bp_second got valid=%b imm=%h inst=%h expected 1/2/00200093", out_valid, out_imm, out_inst);
        end
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0 || imm_count !== 32'd2 || out_imm !== 32'h2) begin
            miscompares++; $display("FAIL bp_drain got valid=%b count=%0d imm=%h expected 0/2/2", out_valid, imm_count, out_imm);
        end
    endtask

    task automatic test_flush();
        do_reset();
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; in_inst = 32'h00A00093; in_itype = 3'd0;
        @(negedge clk);
        in_inst = 32'h00B00093;
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            miscompares++; $display("FAIL flush_pre got valid=%b ready=%b expected 1/0", out_valid, in_ready);
        end
        flush = 1'b1;
        in_inst = 32'h00C00093;
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++; $display("FAIL flush_full got valid=%b ready=%b expected 0/1", out_valid, in_ready);
        end
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_no_late got valid=%b expected 0", out_valid); end
        in_valid = 1'b1; in_inst = 32'h00D00093;
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b1 || out_imm !== 32'hD) begin
            miscompares++; $display("FAIL flush_refill got valid=%b imm=%h expected 1/d", out_valid, out_imm);
        end
        flush = 1'b1;
        in_inst = 32'h00E00093;
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin miscompares++; $display("FAIL flush_blocks_input got ready=%b expected 0", in_ready); end
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_partial got valid=%b expected 0", out_valid); end
        out_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0 || imm_count !== 32'd0) begin
            miscompares++; $display("FAIL flush_count got valid=%b count=%0d expected 0/0", out_valid, imm_count);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b1; in_inst = 32'h00100093; in_itype = 3'd0;
        @(negedge clk);
        in_inst = 32'h00700093;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b1 || out_imm !== 32'h7 || imm_count !== 32'd1) begin
            miscompares++; $display("FAIL rmid_pre got valid=%b imm=%h count=%0d expected 1/7/1", out_valid, out_imm, imm_count);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || imm_count !== 32'd0 || out_imm !== 32'h0) begin
            miscompares++; $display("FAIL rmid_async got valid=%b count=%0d imm=%h expected 0/0/0", out_valid, imm_count, out_imm);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++; $display("FAIL rmid_release got ready=%b valid=%b expected 1/0", in_ready, out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_shift();
        test_formats();
        test_backpressure();
        test_flush();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
